// File: rtl/tcu_drl_align_acc.sv
// Alignment and accumulation stage of the DRL FEDP datapath: finds the largest term
// exponent, shifts every term to it, and sums the terms into a WA-bit accumulator with sticky.

package tcu_drl_pkg;
    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fedp_excep_t;
endpackage

module tcu_drl_align_acc
    import tcu_drl_pkg::*;
#(
    parameter int N      = 5,
    parameter int W      = 25,
    parameter int WA     = 30,
    parameter int EXP_W  = 10,
    parameter int C_HI_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_in,
    output logic                ready_in,
    input  logic [31:0]         req_id_in,
    input  logic [N*EXP_W-1:0]  term_exps,
    input  logic [N*W-1:0]      term_sigs,
    input  logic [N-1:0]        term_mask,
    input  logic                is_int_in,
    input  logic [C_HI_W-1:0]   cval_hi_in,
    input  fedp_excep_t         excep_in,
    output logic                valid_out,
    input  logic                ready_out,
    output logic [31:0]         req_id_out,
    output logic [EXP_W-1:0]    max_exp,
    output logic [WA-1:0]       acc_sig,
    output logic                sticky,
    output logic                is_int_out,
    output logic [C_HI_W-1:0]   cval_hi_out,
    output fedp_excep_t         excep_out
);

    // Shift amounts are one bit wider than the exponents so max - min never wraps.
    localparam int SH_W = EXP_W + 1;
    localparam logic [SH_W-1:0] W_LIM = SH_W'(W);

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // S2 advances when it is empty or downstream is ready; S1 advances when it is
    // empty or S2 advances. ready_in depends on ready_out only, never on valid_in.
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !valid_out || ready_out;
    assign s1_adv   = !s1_valid || s2_adv;
    assign ready_in = s1_adv;

    logic signed [EXP_W-1:0] max_c;
    logic [N*SH_W-1:0]       shift_c;
    logic [N-1:0]            mask_c;

    always_comb begin
        logic                    any;
        logic signed [EXP_W-1:0] e;
        max_c   = '0;
        shift_c = '0;
        mask_c  = term_mask;
        any     = 1'b0;
        e       = '0;
        if (is_int_in) begin
            // Integer mode: every term participates unshifted.
            mask_c = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                e = term_exps[i*EXP_W +: EXP_W];
                if (term_mask[i] && (!any || e > max_c)) begin
                    max_c = e;
                    any   = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                e = term_exps[i*EXP_W +: EXP_W];
                shift_c[i*SH_W +: SH_W] = {max_c[EXP_W-1], max_c} - {e[EXP_W-1], e};
            end
        end
    end

    logic [EXP_W-1:0]  s1_max;
    logic [N*SH_W-1:0] s1_shift;
    logic [N*W-1:0]    s1_sigs;
    logic [N-1:0]      s1_mask;
    logic [31:0]       s1_id;
    logic              s1_is_int;
    logic [C_HI_W-1:0] s1_cval;
    fedp_excep_t       s1_excep;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_max    <= '0;
            s1_shift  <= '0;
            s1_sigs   <= '0;
            s1_mask   <= '0;
            s1_id     <= '0;
            s1_is_int <= 1'b0;
            s1_cval   <= '0;
            s1_excep  <= '0;
        end else if (s1_adv) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_max    <= max_c;
                s1_shift  <= shift_c;
                s1_sigs   <= term_sigs;
                s1_mask   <= mask_c;
                s1_id     <= req_id_in;
                s1_is_int <= is_int_in;
                s1_cval   <= cval_hi_in;
                s1_excep  <= excep_in;
            end
        end
    end

    logic [WA-1:0] sum_c;
    logic          sticky_c;

    always_comb begin
        logic signed [W-1:0]  sig;
        logic signed [WA-1:0] ext;
        logic [SH_W-1:0]      d;
        logic [W-1:0]         low;
        sum_c    = '0;
        sticky_c = 1'b0;
        sig      = '0;
        ext      = '0;
        d        = '0;
        low      = '0;
        for (int i = 0; i < N; i++) begin
            sig = s1_sigs[i*W +: W];
            d   = s1_shift[i*SH_W +: SH_W];
            if (s1_mask[i]) begin
                if (d < W_LIM) begin
                    ext      = {{(WA-W){sig[W-1]}}, sig};
                    ext      = ext >>> d;
                    low      = ~({W{1'b1}} << d);
                    sticky_c = sticky_c | (|(sig & low));
                    sum_c    = sum_c + ext;
                end else begin
                    // Term lies entirely below the accumulator LSB.
                    sticky_c = sticky_c | (|sig);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_out   <= 1'b0;
            req_id_out  <= '0;
            max_exp     <= '0;
            acc_sig     <= '0;
            sticky      <= 1'b0;
            is_int_out  <= 1'b0;
            cval_hi_out <= '0;
            excep_out   <= '0;
        end else if (s2_adv) begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                req_id_out  <= s1_id;
                max_exp     <= s1_max;
                acc_sig     <= sum_c;
                sticky      <= sticky_c;
                is_int_out  <= s1_is_int;
                cval_hi_out <= s1_cval;
                excep_out   <= s1_excep;
            end
        end
    end

endmodule

// File: tb/tb_tcu_drl_align_acc.sv
// Bench for tcu_drl_align_acc: directed and random requests, expected results queued
// at acceptance and popped by an output monitor.

module tb_tcu_drl_align_acc;
    import tcu_drl_pkg::*;

    localparam int N      = 5;
    localparam int W      = 25;
    localparam int WA     = 30;
    localparam int EXP_W  = 10;
    localparam int C_HI_W = 8;

    typedef struct packed {
        logic [31:0]        id;
        logic [N*EXP_W-1:0] exps;
        logic [N*W-1:0]     sigs;
        logic [N-1:0]       mask;
        logic               is_int;
        logic [C_HI_W-1:0]  cval;
        fedp_excep_t        excep;
    } req_t;

    typedef struct packed {
        logic [31:0]       id;
        logic [EXP_W-1:0]  mx;
        logic [WA-1:0]     acc;
        logic              stk;
        logic              is_int;
        logic [C_HI_W-1:0] cval;
        fedp_excep_t       excep;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic               valid_in;
    logic               ready_in;
    logic [31:0]        req_id_in;
    logic [N*EXP_W-1:0] term_exps;
    logic [N*W-1:0]     term_sigs;
    logic [N-1:0]       term_mask;
    logic               is_int_in;
    logic [C_HI_W-1:0]  cval_hi_in;
    fedp_excep_t        excep_in;
    logic               valid_out;
    logic               ready_out;
    logic [31:0]        req_id_out;
    logic [EXP_W-1:0]   max_exp;
    logic [WA-1:0]      acc_sig;
    logic               sticky;
    logic               is_int_out;
    logic [C_HI_W-1:0]  cval_hi_out;
    fedp_excep_t        excep_out;

    tcu_drl_align_acc #(
        .N(N), .W(W), .WA(WA), .EXP_W(EXP_W), .C_HI_W(C_HI_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_in(valid_in), .ready_in(ready_in),
        .req_id_in(req_id_in), .term_exps(term_exps), .term_sigs(term_sigs),
        .term_mask(term_mask), .is_int_in(is_int_in), .cval_hi_in(cval_hi_in),
        .excep_in(excep_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .req_id_out(req_id_out), .max_exp(max_exp), .acc_sig(acc_sig),
        .sticky(sticky), .is_int_out(is_int_out), .cval_hi_out(cval_hi_out),
        .excep_out(excep_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rnd_bp   = 1'b0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic over the alignment rules.
    function automatic exp_t model(req_t r);
        exp_t                    x;
        longint                  sum, s, a;
        int                      mx, e, d;
        bit                      any, stk;
        logic signed [W-1:0]     sg;
        logic signed [EXP_W-1:0] eg;
        sum = 0; mx = 0; any = 0; stk = 0;
        if (r.is_int) begin
            for (int i = 0; i < N; i++) begin
                sg = r.sigs[i*W +: W];
                s = sg;
                sum += s;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r.mask[i]) begin
                    eg = r.exps[i*EXP_W +: EXP_W];
                    e = eg;
                    if (!any || e > mx) mx = e;
                    any = 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (r.mask[i]) begin
                    eg = r.exps[i*EXP_W +: EXP_W];
                    e = eg;
                    d = mx - e;
                    sg = r.sigs[i*W +: W];
                    s = sg;
                    if (d >= W) begin
                        if (s != 0) stk = 1;
                    end else begin
                        a = s >>> d;
                        if ((a <<< d) != s) stk = 1;
                        sum += a;
                    end
                end
            end
        end
        x.id = r.id; x.mx = EXP_W'(mx); x.acc = WA'(sum); x.stk = stk;
        x.is_int = r.is_int; x.cval = r.cval; x.excep = r.excep;
        return x;
    endfunction

    function automatic req_t mk(logic [31:0] id);
        req_t r;
        r = '0;
        r.id = id;
        r.cval = C_HI_W'($urandom);
        r.excep = fedp_excep_t'(5'($urandom));
        return r;
    endfunction

    function automatic req_t term(req_t r, int i, int e, int s);
        r.exps[i*EXP_W +: EXP_W] = EXP_W'(e);
        r.sigs[i*W +: W] = W'(s);
        r.mask[i] = 1'b1;
        return r;
    endfunction

    function automatic exp_t xp(req_t r, int mx, logic [WA-1:0] acc, bit stk);
        exp_t x;
        x.id = r.id; x.mx = EXP_W'(mx); x.acc = acc; x.stk = stk;
        x.is_int = r.is_int; x.cval = r.cval; x.excep = r.excep;
        return x;
    endfunction

    function automatic req_t rand_req(logic [31:0] id);
        req_t r;
        int   base, e;
        r = mk(id);
        r.is_int = ($urandom_range(0, 7) == 0);
        r.mask = N'($urandom);
        base = int'($urandom_range(0, 1023)) - 512;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                e = base - int'($urandom_range(0, 30));
                if (e < -512) e = -512;
            end else begin
                e = int'($urandom_range(0, 1023)) - 512;
            end
            r.exps[i*EXP_W +: EXP_W] = EXP_W'(e);
            r.sigs[i*W +: W] = W'($urandom);
        end
        return r;
    endfunction

    // driver tasks
    task automatic send(input req_t r, input exp_t x);
        bit ok;
        ok = 0;
        valid_in = 1'b1; req_id_in = r.id; term_exps = r.exps; term_sigs = r.sigs;
        term_mask = r.mask; is_int_in = r.is_int; cval_hi_in = r.cval; excep_in = r.excep;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ready_in) begin
                exp_q.push_back(x);
                ok = 1;
            end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout id=%0d ready_in got 0 required 1", r.id);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", nm, got, want);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_valid_out"}, 64'(valid_out), 64'd0);
        chk({nm, "_req_id"}, 64'(req_id_out), 64'd0);
        chk({nm, "_max_exp"}, 64'(max_exp), 64'd0);
        chk({nm, "_acc_sig"}, 64'(acc_sig), 64'd0);
        chk({nm, "_sticky"}, 64'(sticky), 64'd0);
        chk({nm, "_is_int"}, 64'(is_int_out), 64'd0);
        chk({nm, "_cval_hi"}, 64'(cval_hi_out), 64'd0);
        chk({nm, "_excep"}, 64'(excep_out), 64'd0);
        chk({nm, "_ready_in"}, 64'(ready_in), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout outstanding got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // random backpressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_bp) ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    exp_t held;
    bit   held_vld = 1'b0;

    always @(negedge clk) begin
        exp_t got, x;
        got.id = req_id_out; got.mx = max_exp; got.acc = acc_sig; got.stk = sticky;
        got.is_int = is_int_out; got.cval = cval_hi_out; got.excep = excep_out;
        if (!reset_n) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                n_checks++;
                if (!valid_out || got != held) begin
                    n_fail++;
                    $display("FAIL stall_hold got valid=%0b out=%0h required valid=1 out=%0h",
                             valid_out, got, held);
                end
            end
            if (valid_out && ready_out) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got id=%0d required no output", req_id_out);
                end else begin
                    x = exp_q.pop_front();
                    if (got !== x) begin
                        n_fail++;
                        $display("FAIL result id=%0d got max=%0h acc=%0h stk=%0b int=%0b cval=%0h exc=%0h required id=%0d max=%0h acc=%0h stk=%0b int=%0b cval=%0h exc=%0h",
                                 got.id, got.mx, got.acc, got.stk, got.is_int, got.cval, got.excep,
                                 x.id, x.mx, x.acc, x.stk, x.is_int, x.cval, x.excep);
                    end
                end
            end
            held_vld = valid_out && !ready_out;
            held = got;
        end
    end

    initial begin
        req_t r;
        reset_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        req_id_in = '0; term_exps = '0; term_sigs = '0; term_mask = '0;
        is_int_in = 1'b0; cval_hi_in = '0; excep_in = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_idle("rst_init");
        @(posedge clk); #1;

        // directed cases
        r = mk(1); r = term(r, 0, 10, 'h100000); r = term(r, 1, 10, 'h100000);
        send(r, xp(r, 10, 30'h0200000, 1'b0));
        r = mk(2); r = term(r, 0, 12, 'h400000); r = term(r, 1, 10, 3);
        send(r, xp(r, 12, 30'h0400000, 1'b1));
        r = mk(3); r = term(r, 0, 5, -8); r = term(r, 1, 5, 3);
        send(r, xp(r, 5, 30'h3FFFFFFB, 1'b0));
        r = mk(4); r = term(r, 0, 5, -8); r = term(r, 1, 5, 3); r = term(r, 2, -35, 1);
        send(r, xp(r, 5, 30'h3FFFFFFB, 1'b1));
        r = mk(5); r.is_int = 1'b1;
        r = term(r, 0, 0, 100); r = term(r, 1, 0, -30); r = term(r, 2, 0, 7);
        r = term(r, 3, 0, 0); r = term(r, 4, 0, 5);
        r.exps = {2{25'($urandom)}}; r.mask = N'($urandom);
        send(r, xp(r, 0, 30'd82, 1'b0));
        r = mk(6); r = term(r, 0, 7, 99); r = term(r, 3, -4, -5); r.mask = '0;
        send(r, xp(r, 0, 30'd0, 1'b0));
        r = mk(7); r = term(r, 0, 511, 5); r = term(r, 1, -512, -1); r = term(r, 2, 511, -7);
        send(r, xp(r, 511, 30'h3FFFFFFE, 1'b1));
        r = mk(8); r = term(r, 0, 100, 0); r = term(r, 1, 76, -'h1000000);
        send(r, xp(r, 100, 30'h3FFFFFFF, 1'b0));
        r = mk(9); r = term(r, 0, 100, 0); r = term(r, 1, 75, 1);
        send(r, xp(r, 100, 30'd0, 1'b1));
        drain();

        // backpressure: four back-to-back requests, ready_out low for 3 cycles
        @(posedge clk); #1;
        ready_out = 1'b0;
        fork
            begin
                req_t rb;
                for (int k = 0; k < 4; k++) begin
                    rb = rand_req(32'(50 + k));
                    send(rb, model(rb));
                end
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_ready_in_low", 64'(ready_in), 64'd0);
        chk("bp_valid_out", 64'(valid_out), 64'd1);
        @(posedge clk); #1;
        ready_out = 1'b1;
        wait fork;
        drain();

        // reset with both stages full
        @(posedge clk); #1;
        ready_out = 1'b0;
        r = rand_req(60); send(r, model(r));
        r = rand_req(61); send(r, model(r));
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1; ready_out = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid");
        @(posedge clk); #1;
        r = mk(62); r = term(r, 0, -3, 1000); r = term(r, 4, -3, -1);
        send(r, xp(r, -3, 30'd999, 1'b0));
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(valid_out), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(valid_out), 64'd1);
        drain();

        // random traffic with random backpressure
        @(posedge clk); #1;
        rnd_bp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            r = rand_req(32'(100 + k));
            send(r, model(r));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_bp = 1'b0;
        ready_out = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcu_drl_align_acc.md
Name: tcu_drl_align_acc

Overview:
Pipelined alignment and accumulation stage of the DRL FEDP datapath. It sits directly upstream of the normalize/round stage. Each request carries N signed, exponent-tagged terms: N-1 product significands plus the C addend. The block finds the maximum exponent, arithmetically right-shifts every term to that exponent, sums the terms into a WA-bit two's-complement accumulator and collects a sticky bit. It emits max_exp, acc_sig and sticky with a valid/ready handshake and passes the side-band fields through unchanged.

Parameters:
N, 5, terms per request (N-1 products + 1 C term at index N-1)
W, 25, term significand width (two's complement)
WA, 30, accumulator width; WA-W headroom bits, must satisfy WA-W >= clog2(N)
EXP_W, 10, signed exponent width
C_HI_W, 8, width of integer C upper-bits side-band

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
valid_in  in  1  request valid
ready_in  out  1  block can accept a request
req_id_in  in  32  request tag
term_exps  in  N*EXP_W  signed exponent per term, term i at [i*EXP_W +: EXP_W]
term_sigs  in  N*W  signed significand per term, term i at [i*W +: W]
term_mask  in  N  1 = term participates; 0 = zero or absent operand
is_int_in  in  1  integer mode
cval_hi_in  in  C_HI_W  integer C upper bits (pass-through)
excep_in  in  fedp_excep_t  exception flags (pass-through)
valid_out  out  1  result valid
ready_out  in  1  downstream accepts
req_id_out  out  32  tag
max_exp  out  EXP_W  alignment exponent
acc_sig  out  WA  two's-complement aligned sum
sticky  out  1  OR of all bits discarded during alignment
is_int_out  out  1  pass-through
cval_hi_out  out  C_HI_W  pass-through
excep_out  out  fedp_excep_t  pass-through

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on reset_n. While reset_n=0 at a clk edge, both stage valid bits and all output data registers clear to 0, so valid_out=0 and max_exp, acc_sig, sticky, req_id_out, cval_hi_out, excep_out, is_int_out are all 0. ready_in=1 in the cycle after reset releases. Any request in flight when reset asserts is dropped.
- Pipeline: two register stages, S1 and S2.
  - S1: computes the signed maximum of term_exps over the masked-in terms. It registers the max, per-term shift amounts d_i = max - exp_i, the sigs, the mask and the side-band fields.
  - S2: performs the shifts, the sum and the sticky, and drives the output registers.
- Latency: 2 cycles, from the accepting edge to valid_out when there are no stalls. Throughput: 1 request per cycle.
- Handshake:
  - A transfer occurs on an edge where valid/ready are both 1.
  - S2 advances when !s2_valid || ready_out.
  - S1 advances when !s1_valid || S2 advances.
  - ready_in = (!s1_valid || S2 advances). This is combinational from ready_out, with no combinational path from valid_in.
  - Outputs hold stable while valid_out=1 and ready_out=0.
  - Bubbles collapse. Ordering is strictly preserved, and no request is lost or duplicated.
- Alignment, for a masked-in term i:
  - If d_i < W: aligned_i = sign-extend_WA(sig_i >>> d_i). The discarded bits sig_i[d_i-1:0] are ORed into sticky.
  - If d_i >= W: aligned_i = 0, and sticky |= (sig_i != 0).
- Masked-out terms contribute 0 to the sum and nothing to sticky.
- acc_sig = sum of the aligned terms, modulo 2^WA. Headroom guarantees no overflow for N <= 2^(WA-W).
- All terms masked: max_exp=0, acc_sig=0, sticky=0.
- Integer mode (is_int_in=1): exponents and mask are ignored, and all shifts are forced to 0. acc_sig = sum of sign-extended sigs, max_exp=0, sticky=0.
- Exponent ties: equal maxima give d=0 and are legal.
- Exponent range: exponents span the full signed EXP_W range. The difference is computed at EXP_W+1 bits, so it never wraps.

Test Plan:
- Equal exponents: t0 = exp 10, sig 0x100000; t1 = exp 10, sig 0x100000; others masked -> after 2 cycles: max_exp=10, acc_sig=0x0200000, sticky=0.
- Alignment loss: t0 = exp 12, sig 0x400000; t1 = exp 10, sig 0x3 -> max_exp=12, acc_sig=0x0400000, sticky=1.
- Negative sum and far shift:
  - t0 = exp 5, sig -8; t1 = exp 5, sig 3 -> acc_sig=0x3FFFFFFB, sticky=0.
  - Adding t2 = exp -35, sig 1 (d=40) -> same acc_sig, sticky=1.
- Integer mode: is_int_in=1, sigs 100, -30, 7, 0, 5 with random exponents -> acc_sig=82, max_exp=0, sticky=0; cval_hi_out and excep_out equal the inputs.
- Backpressure: stream 4 back-to-back requests with ready_out held 0 for 3 cycles -> ready_in drops once S1 and S2 are both full; once ready_out rises, results emerge in id order with no loss; outputs stay stable while stalled.
- Reset mid-operation: drive reset_n=0 for 1 cycle with both stages full -> next cycle valid_out=0, all outputs 0, ready_in=1; a request sent afterwards completes after 2 cycles.
